key_pulse_gen: RTL and testbench
================================

KEY_PULSE_GEN -- requirements
Module: key_pulse_gen

Interface
REQ-001 Parameter N_KEYS, default 4, number of independent key channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 1000000, stable-level cycles for press/release acceptance (20 ms at 50 MHz).
REQ-003 Parameter REPEAT_DELAY_CYCLES, default 25000000, hold time before the first auto-repeat pulse.
REQ-004 Parameter REPEAT_RATE_CYCLES, default 5000000, interval between subsequent auto-repeat pulses.
REQ-005 Port CLOCK_50  in  1  sole clock; all logic on rising edge.
REQ-006 Port RESET  in  1  asynchronous, active-high reset.
REQ-007 Port KEY  in  N_KEYS  raw pushbutton inputs, active-low (0 = pressed), asynchronous to CLOCK_50.
REQ-008 Port KEY_PULSE  out  N_KEYS  one-cycle active-high pulse per accepted press or repeat; drives the date counters' increment inputs.
REQ-009 Port KEY_LEVEL  out  N_KEYS  debounced pressed state, active-high.

Function
REQ-010 Each KEY bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-011 Each channel SHALL run an independent FSM: IDLE, PRESS_DB, HELD, RELEASE_DB.
REQ-012 IDLE -> PRESS_DB when synchronized key reads pressed; counter cleared.
REQ-013 PRESS_DB: counter increments each cycle key stays pressed; any released sample returns to IDLE (bounce restarts acceptance).
REQ-014 PRESS_DB -> HELD when counter reaches DEBOUNCE_CYCLES-1; KEY_PULSE asserted for exactly the following cycle, KEY_LEVEL set at the same cycle.
REQ-015 Press latency: first KEY_PULSE cycle = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles after the KEY falling edge, given no bounce.
REQ-016 HELD -> RELEASE_DB on a released sample; RELEASE_DB returns to HELD on any pressed sample.
REQ-017 RELEASE_DB -> IDLE after DEBOUNCE_CYCLES consecutive released samples; KEY_LEVEL cleared then; no pulse on release.
REQ-018 KEY_PULSE on one channel SHALL never be high in two consecutive cycles.
REQ-019 Channels SHALL be fully independent; simultaneous presses give same-cycle pulses on each channel.
REQ-020 Counters SHALL be $clog2 of the largest cycle parameter wide, saturate at terminal, never wrap.

Reset
REQ-021 RESET SHALL asynchronously force all FSMs to IDLE, all counters to 0, synchronizer flops to 1 (released), KEY_PULSE and KEY_LEVEL to 0.
REQ-022 No KEY_PULSE SHALL occur during RESET or in the 2 cycles following deassertion.
REQ-023 A key held through RESET deassertion SHALL be treated as a new press: exactly one pulse after full debounce.
REQ-024 RESET asserted mid-debounce or mid-repeat SHALL abort without emitting a pulse.

Configuration
REQ-025 Macro KEY_AUTOREPEAT_EN defined: in HELD, after REPEAT_DELAY_CYCLES continuous hold from the press pulse, one KEY_PULSE; then one every REPEAT_RATE_CYCLES until release is seen; repeat timer cleared on entering RELEASE_DB and not resumed on bounce back.
REQ-026 Macro KEY_AUTOREPEAT_EN undefined: exactly one KEY_PULSE per accepted press regardless of hold time; repeat counters and REPEAT_* parameters unused (no repeat logic synthesized).

Structure
REQ-027 Package key_pulse_pkg SHALL hold the channel state enum and default parameter constants.
REQ-028 Sub-module key_debounce_ch SHALL implement one channel (synchronizer, FSM, counters); key_pulse_gen instantiates it N_KEYS times via generate.

Verification (bench params: DEBOUNCE_CYCLES=8, REPEAT_DELAY_CYCLES=40, REPEAT_RATE_CYCLES=10)
REQ-029 Clean press KEY[0]=0 held 30 cycles -> single KEY_PULSE[0] at cycle 11 after edge; KEY_LEVEL[0] high until 8 cycles after release seen.
REQ-030 Bounce: KEY[1] toggles every 3 cycles for 20 cycles then stays low -> exactly one pulse, 11 cycles after final settle.
REQ-031 Glitch: KEY[2] low for 5 cycles then high -> no pulse, KEY_LEVEL[2] stays 0.
REQ-032 KEY_AUTOREPEAT_EN defined, KEY[0] held 100 cycles -> pulses at press+0, +40, +50, +60, ... (7 total); undefined -> 1 pulse.
REQ-033 KEY[0] and KEY[3] pressed same cycle -> both pulses in same cycle; RESET asserted 4 cycles into PRESS_DB on KEY[1] -> outputs 0 immediately, no pulse until re-debounced after deassertion.

Source files
------------

// File: rtl/key_pulse_pkg.sv
// Shared types and default constants for the key pulse generator.
// Auto-repeat is enabled by defining KEY_AUTOREPEAT_EN at build time.
package key_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } key_state_t;

  localparam int DEF_N_KEYS              = 4;
  localparam int DEF_DEBOUNCE_CYCLES     = 1000000;
  localparam int DEF_REPEAT_DELAY_CYCLES = 25000000;
  localparam int DEF_REPEAT_RATE_CYCLES  = 5000000;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchronizer, debounce FSM and optional auto-repeat.
// Auto-repeat logic exists only when KEY_AUTOREPEAT_EN is defined.
module key_debounce_ch
  import key_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic pulse,
  output logic level
);

  localparam int CNT_MAXVAL = max3(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);
  localparam int CNT_W = ($clog2(CNT_MAXVAL) < 1) ? 1 : $clog2(CNT_MAXVAL);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef KEY_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE_CYCLES - 1);
`endif

  logic [1:0]       sync;
  logic             pressed;
  key_state_t       state;
  logic [CNT_W-1:0] cnt;
`ifdef KEY_AUTOREPEAT_EN
  logic             repeating;
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Synchronizer resets to the released level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= 2'b11;
    else     sync <= {sync[0], key_n};
  end

  assign pressed = ~sync[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      repeating <= 1'b0;
`endif
    end else begin
      pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (pressed) begin
            state <= PRESS_DB;
            cnt   <= '0;
          end
        end
        PRESS_DB: begin
          if (!pressed) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= HELD;
            cnt   <= '0;
            pulse <= 1'b1;
            level <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            repeating <= 1'b0;
`endif
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        HELD: begin
          if (!pressed) begin
            state <= RELEASE_DB;
            cnt   <= '0;
          end else begin
`ifdef KEY_AUTOREPEAT_EN
            // First repeat waits the long delay, later ones the rate; never back-to-back.
            if ((cnt >= (repeating ? RATE_LAST : DELAY_LAST)) && !pulse) begin
              pulse     <= 1'b1;
              cnt       <= '0;
              repeating <= 1'b1;
            end else begin
              cnt <= sat_inc(cnt);
            end
`endif
          end
        end
        RELEASE_DB: begin
          if (pressed) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DB_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
          end else begin
            cnt <= sat_inc(cnt);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_pulse_gen.sv
// Debounced one-shot pulse generator for N_KEYS active-low pushbuttons.
// Define KEY_AUTOREPEAT_EN to add hold-to-repeat pulses.
module key_pulse_gen
  import key_pulse_pkg::*;
#(
  parameter int N_KEYS              = DEF_N_KEYS,
  parameter int DEBOUNCE_CYCLES     = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
) (
  input  logic              CLOCK_50,
  input  logic              RESET,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] KEY_PULSE,
  output logic [N_KEYS-1:0] KEY_LEVEL
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DEBOUNCE_CYCLES    (DEBOUNCE_CYCLES),
      .REPEAT_DELAY_CYCLES(REPEAT_DELAY_CYCLES),
      .REPEAT_RATE_CYCLES (REPEAT_RATE_CYCLES)
    ) u_ch (
      .clk  (CLOCK_50),
      .rst  (RESET),
      .key_n(KEY[i]),
      .pulse(KEY_PULSE[i]),
      .level(KEY_LEVEL[i])
    );
  end

endmodule

// File: tb/tb_key_pulse_gen.sv
// Directed bench for key_pulse_gen with short debounce/repeat parameters.
// Expected repeat counts follow KEY_AUTOREPEAT_EN as defined for the build.
module tb_key_pulse_gen;

  localparam int NK = 4;
`ifdef KEY_AUTOREPEAT_EN
  localparam int EXP_HOLD_PULSES = 7;
  localparam int EXP_HOLD_LAST   = 101;
`else
  localparam int EXP_HOLD_PULSES = 1;
  localparam int EXP_HOLD_LAST   = 11;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NK-1:0] key = '1;
  logic [NK-1:0] key_pulse;
  logic [NK-1:0] key_level;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;
  int pcount[NK];
  int first[NK];
  int last[NK];
  logic [NK-1:0] prev_pulse = '0;
  logic [NK-1:0] level_seen = '0;

  key_pulse_gen #(
    .N_KEYS             (NK),
    .DEBOUNCE_CYCLES    (8),
    .REPEAT_DELAY_CYCLES(40),
    .REPEAT_RATE_CYCLES (10)
  ) dut (
    .CLOCK_50 (clk),
    .RESET    (rst),
    .KEY      (key),
    .KEY_PULSE(key_pulse),
    .KEY_LEVEL(key_level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [NK-1:0] k);
    key = k;
  endtask

  task automatic resetCounters();
    base = cyc;
    level_seen = '0;
    for (int c = 0; c < NK; c++) begin
      pcount[c] = 0;
      first[c]  = -1;
      last[c]   = -1;
    end
  endtask

  // Each tick samples 1 time unit after the rising edge and logs pulses per channel.
  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      checkOutput("no_double_pulse", 32'(key_pulse & prev_pulse), 32'd0);
      prev_pulse = key_pulse;
      level_seen = level_seen | key_level;
      for (int c = 0; c < NK; c++) begin
        if (key_pulse[c]) begin
          pcount[c]++;
          if (first[c] < 0) first[c] = cyc - base;
          last[c] = cyc - base;
        end
      end
    end
  endtask

  initial begin
    resetCounters();
    #2 rst = 1'b1;
    #1;
    checkOutput("reset_pulse", 32'(key_pulse), 32'd0);
    checkOutput("reset_level", 32'(key_level), 32'd0);
    runTicks(3);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc++;
    prev_pulse = key_pulse;
    resetCounters();
    runTicks(5);
    checkOutput("idle_no_pulse", 32'(pcount[0] + pcount[1] + pcount[2] + pcount[3]), 32'd0);

    $display("[TB] clean press on KEY[0]");
    resetCounters();
    applyStimulus(4'b1110);
    runTicks(10);
    checkOutput("clean_level_before", 32'(key_level[0]), 32'd0);
    checkOutput("clean_no_early_pulse", 32'(pcount[0]), 32'd0);
    runTicks(1);
    checkOutput("clean_pulse_now", 32'(key_pulse[0]), 32'd1);
    checkOutput("clean_level_now", 32'(key_level[0]), 32'd1);
    checkOutput("clean_first", 32'(first[0]), 32'd11);
    runTicks(19);
    checkOutput("clean_count", 32'(pcount[0]), 32'd1);
    applyStimulus(4'b1111);
    runTicks(10);
    checkOutput("release_level_held", 32'(key_level[0]), 32'd1);
    runTicks(1);
    checkOutput("release_level_clear", 32'(key_level[0]), 32'd0);
    runTicks(5);
    checkOutput("release_no_pulse", 32'(pcount[0]), 32'd1);

    $display("[TB] bouncing KEY[1]");
    resetCounters();
    for (int s = 0; s < 6; s++) begin
      applyStimulus((s % 2 == 0) ? 4'b1101 : 4'b1111);
      runTicks(3);
    end
    applyStimulus(4'b1101);
    runTicks(20);
    checkOutput("bounce_count", 32'(pcount[1]), 32'd1);
    checkOutput("bounce_first", 32'(first[1]), 32'd29);
    checkOutput("bounce_other_ch", 32'(pcount[0] + pcount[2] + pcount[3]), 32'd0);
    applyStimulus(4'b1111);
    runTicks(15);
    checkOutput("bounce_level_clear", 32'(key_level[1]), 32'd0);

    $display("[TB] glitch on KEY[2]");
    resetCounters();
    applyStimulus(4'b1011);
    runTicks(5);
    applyStimulus(4'b1111);
    runTicks(15);
    checkOutput("glitch_count", 32'(pcount[2]), 32'd0);
    checkOutput("glitch_level", 32'(level_seen[2]), 32'd0);

    $display("[TB] long hold on KEY[0]");
    resetCounters();
    applyStimulus(4'b1110);
    runTicks(100);
    applyStimulus(4'b1111);
    runTicks(15);
    checkOutput("hold_count", 32'(pcount[0]), 32'(EXP_HOLD_PULSES));
    checkOutput("hold_first", 32'(first[0]), 32'd11);
    checkOutput("hold_last", 32'(last[0]), 32'(EXP_HOLD_LAST));
    checkOutput("hold_level_clear", 32'(key_level[0]), 32'd0);

    $display("[TB] simultaneous KEY[0] and KEY[3]");
    resetCounters();
    applyStimulus(4'b0110);
    runTicks(20);
    checkOutput("simul_first0", 32'(first[0]), 32'd11);
    checkOutput("simul_first3", 32'(first[3]), 32'd11);
    checkOutput("simul_count0", 32'(pcount[0]), 32'd1);
    checkOutput("simul_count3", 32'(pcount[3]), 32'd1);
    applyStimulus(4'b1111);
    runTicks(15);

    $display("[TB] reset during debounce on KEY[1]");
    applyStimulus(4'b1110);
    runTicks(15);
    checkOutput("pre_reset_level0", 32'(key_level[0]), 32'd1);
    resetCounters();
    applyStimulus(4'b1100);
    runTicks(7);
    rst = 1'b1;
    #1;
    checkOutput("abort_level", 32'(key_level), 32'd0);
    checkOutput("abort_pulse", 32'(key_pulse), 32'd0);
    runTicks(3);
    checkOutput("abort_no_pulse", 32'(pcount[0] + pcount[1]), 32'd0);
    rst = 1'b0;
    resetCounters();
    runTicks(20);
    checkOutput("rearm_first0", 32'(first[0]), 32'd11);
    checkOutput("rearm_first1", 32'(first[1]), 32'd11);
    checkOutput("rearm_count1", 32'(pcount[1]), 32'd1);
    checkOutput("rearm_level1", 32'(key_level[1]), 32'd1);
    applyStimulus(4'b1111);
    runTicks(15);
    checkOutput("final_level", 32'(key_level), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
